// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle TTL ALU: opcode/state enums, latched flag record.
package alu_pkg;
  localparam int ALU_OP_W = 4;

  // Encodings 10..15 are undefined and raise op_err.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_OR   = 4'd0,
    ALU_XOR  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SRL  = 4'd4,
    ALU_ADD  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_e;

  typedef struct packed {
    logic eq;
    logic lt;
    logic ltu;
    logic err;
  } alu_flags_t;

  function automatic logic is_shift(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction
endpackage

// File: rtl/alu_shift_step.sv
// Combinational shift of data by k bits; right/arith select SRL/SRA, else SLL.
module alu_shift_step #(
  parameter int WIDTH = 32,
  parameter int KW    = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  logic             dir_right,
  input  logic             arith,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = data << k;
    if (dir_right) y = arith ? WIDTH'($signed(data) >>> k) : (data >> k);
  end
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake and tri-state result drive.
// ALU_FAST_SHIFT_EN selects a one-cycle barrel shifter instead of the iterative one.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] op,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                bus_en,
  input  logic                addr_en,
  output tri   [WIDTH-1:0]    bus,
  output tri   [WIDTH-1:0]    addr,
  output logic                alu_eq,
  output logic                alu_lt,
  output logic                alu_ltu,
  output logic                op_err
);
  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_e       state;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;
  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic [WIDTH-1:0] sh_y;

  assign amt = b[SHAMT_W-1:0];

`ifdef ALU_FAST_SHIFT_EN
  alu_shift_step #(.WIDTH(WIDTH), .KW(SHAMT_W)) u_shift (
    .data(a), .k(amt), .dir_right(op != ALU_SLL), .arith(op == ALU_SRA), .y(sh_y)
  );
`else
  localparam int KW = $clog2(SHIFT_STEP + 1);
  logic [WIDTH-1:0]    acc;
  logic [SHAMT_W-1:0]  cnt, cnt_nxt;
  logic [ALU_OP_W-1:0] op_q;
  logic [SHAMT_W:0]    step_w;

  // Last step may be shorter than SHIFT_STEP when the amount isn't a multiple.
  assign step_w  = ({1'b0, cnt} >= (SHAMT_W+1)'(SHIFT_STEP)) ? (SHAMT_W+1)'(SHIFT_STEP) : {1'b0, cnt};
  assign cnt_nxt = cnt - step_w[SHAMT_W-1:0];

  alu_shift_step #(.WIDTH(WIDTH), .KW(KW)) u_shift (
    .data(acc), .k(KW'(step_w)), .dir_right(op_q != ALU_SLL), .arith(op_q == ALU_SRA), .y(sh_y)
  );
`endif

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op)
      ALU_OR:   alu_res = a | b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_AND:  alu_res = a & b;
      ALU_ADD:  alu_res = a + b;
      ALU_SUB:  alu_res = a - b;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = sh_y;
      default:  alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
`ifndef ALU_FAST_SHIFT_EN
      acc      <= '0;
      cnt      <= '0;
      op_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid && !flush) begin
          flags_q <= {a == b, $signed(a) < $signed(b), a < b, alu_err};
`ifdef ALU_FAST_SHIFT_EN
          result_q <= alu_res;
          state    <= DONE;
`else
          if (is_shift(op) && amt != '0) begin
            acc   <= a;
            cnt   <= amt;
            op_q  <= op;
            state <= SHIFT;
          end else begin
            result_q <= is_shift(op) ? a : alu_res;
            state    <= DONE;
          end
`endif
        end
`ifdef ALU_FAST_SHIFT_EN
        SHIFT: state <= IDLE;
`else
        SHIFT: if (flush) state <= IDLE;
        else begin
          acc <= sh_y;
          cnt <= cnt_nxt;
          if (cnt_nxt == '0) begin
            result_q <= sh_y;
            state    <= DONE;
          end
        end
`endif
        DONE: if (flush || out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign alu_eq    = flags_q.eq;
  assign alu_lt    = flags_q.lt;
  assign alu_ltu   = flags_q.ltu;
  assign op_err    = flags_q.err;

  assign bus  = bus_en  ? result_q : 'z;
  assign addr = addr_en ? result_q : 'z;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: spec vector table, random ops vs. reference model,
// and hand-written stall / flush / reset sequences.
module tb_alu_seq;
  import alu_pkg::*;
  localparam int W = 32, STEP = 4;
`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0, bus_en = 0, addr_en = 1;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0] op = '0;
  wire  [W-1:0] bus, addr;
  logic in_ready, out_valid, alu_eq, alu_lt, alu_ltu, op_err;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .bus_en(bus_en),
    .addr_en(addr_en), .bus(bus), .addr(addr), .alu_eq(alu_eq), .alu_lt(alu_lt),
    .alu_ltu(alu_ltu), .op_err(op_err)
  );

  typedef struct {logic [W-1:0] res; logic [3:0] fl; int lat;} exp_t;
  typedef struct {logic [W-1:0] a, b; logic [3:0] op; logic [W-1:0] res; logic [3:0] fl; int lat;} vec_t;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Reference: plain arithmetic on the operands; latency from the shift-amount rule.
  function automatic exp_t model(input logic [W-1:0] av, bv, input logic [3:0] opv);
    exp_t e;
    int amt = int'(bv[4:0]);
    e.fl = {av == bv, $signed(av) < $signed(bv), av < bv, 1'b0};
    e.lat = 1;
    case (opv)
      4'd0: e.res = av | bv;
      4'd1: e.res = av ^ bv;
      4'd2: e.res = av & bv;
      4'd3: e.res = av << amt;
      4'd4: e.res = av >> amt;
      4'd5: e.res = av + bv;
      4'd6: e.res = av - bv;
      4'd7: e.res = W'($signed(av) >>> amt);
      4'd8: e.res = ($signed(av) < $signed(bv)) ? 1 : 0;
      4'd9: e.res = (av < bv) ? 1 : 0;
      default: begin e.res = '0; e.fl[0] = 1'b1; end
    endcase
    if (!FAST && (opv == 4'd3 || opv == 4'd4 || opv == 4'd7) && amt != 0)
      e.lat = 1 + (amt + STEP - 1) / STEP;
    return e;
  endfunction

  task automatic do_op(input logic [W-1:0] av, bv, input logic [3:0] opv, input exp_t e,
                       input string nm, input int hold);
    int n = 0, lat = 1;
    while (!in_ready && n < 50) begin tick; n++; end
    chk({nm, ".in_ready"}, W'(in_ready), W'(1));
    a = av; b = bv; op = opv; in_valid = 1;
    tick;
    in_valid = 0;
    while (!out_valid && lat < 80) begin tick; lat++; end
    chk({nm, ".lat"}, W'(lat), W'(e.lat));
    chk({nm, ".res"}, addr, e.res);
    chk({nm, ".flags"}, W'({alu_eq, alu_lt, alu_ltu, op_err}), W'(e.fl));
    for (int i = 0; i < hold; i++) begin
      tick;
      chk({nm, ".hold"}, {addr[W-2:0], out_valid}, {e.res[W-2:0], 1'b1});
    end
    out_ready = 1;
    tick;
    out_ready = 0;
    chk({nm, ".release"}, W'({in_ready, out_valid}), W'(2'b10));
  endtask

  vec_t vt[15];
  exp_t e;
  logic [W-1:0] prev;
  bit seen;

  initial begin
    vt[0]  = '{32'hFFFF_FFFF, 32'h1,          4'd5,  32'h0,         4'b0100, 1};
    vt[1]  = '{32'h8000_0000, 32'h24,         4'd7,  32'hF800_0000, 4'b0100, 2};
    vt[2]  = '{32'h1,         32'h0,          4'd3,  32'h1,         4'b0000, 1};
    vt[3]  = '{32'h1,         32'h1F,         4'd3,  32'h8000_0000, 4'b0110, 9};
    vt[4]  = '{32'h5,         32'h7,          4'd6,  32'hFFFF_FFFE, 4'b0110, 1};
    vt[5]  = '{32'h12,        32'h12,         4'hF,  32'h0,         4'b1001, 1};
    vt[6]  = '{32'h8000_0000, 32'h1,          4'd8,  32'h1,         4'b0100, 1};
    vt[7]  = '{32'h8000_0000, 32'h1,          4'd9,  32'h0,         4'b0100, 1};
    vt[8]  = '{32'h8000_0000, 32'hFFFF_FFE1,  4'd4,  32'h4000_0000, 4'b0110, 2};
    vt[9]  = '{32'hF0F0_F0F0, 32'hFF00_FF00,  4'd1,  32'h0FF0_0FF0, 4'b0110, 1};
    vt[10] = '{32'h8000_0000, 32'h5,          4'd7,  32'hFC00_0000, 4'b0100, 3};
    vt[11] = '{32'hFF,        32'h0F,         4'd2,  32'h0F,        4'b0000, 1};
    vt[12] = '{32'hF0,        32'hF00,        4'd0,  32'hFF0,       4'b0110, 1};
    vt[13] = '{32'hFFFF_0000, 32'h20,         4'd4,  32'hFFFF_0000, 4'b0100, 1};
    vt[14] = '{32'h3,         32'h2,          4'hA,  32'h0,         4'b0001, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.hs", W'({in_ready, out_valid}), W'(2'b10));
    chk("rst.flags", W'({alu_eq, alu_lt, alu_ltu, op_err}), W'(0));
    chk("rst.result", addr, '0);
    rst = 0;
    tick;

    // Vector table
    foreach (vt[i]) begin
      e.res = vt[i].res;
      e.fl  = vt[i].fl;
      e.lat = (FAST && (vt[i].op == 4'd3 || vt[i].op == 4'd4 || vt[i].op == 4'd7)) ? 1 : vt[i].lat;
      do_op(vt[i].a, vt[i].b, vt[i].op, e, $sformatf("vec%0d", i), 0);
    end

    // Consumer stall: result held, new requests ignored while DONE
    do_op(32'h3, 32'h4, 4'd5, model(32'h3, 32'h4, 4'd5), "stall_pre", 0);
    a = 32'h3; b = 32'h4; op = 4'd5; in_valid = 1;
    tick;
    a = 32'h9; b = 32'h1; op = 4'd6;
    for (int i = 0; i < 5; i++) begin
      chk("stall.state", W'({out_valid, in_ready}), W'(2'b10));
      chk("stall.res", addr, 32'h7);
      tick;
    end
    in_valid = 0; out_ready = 1;
    tick;
    out_ready = 0;
    chk("stall.release", W'({in_ready, out_valid}), W'(2'b10));
    tick;
    chk("stall.no_accept", addr, 32'h7);

    // Flush during shift: back to IDLE, result_q untouched, out_valid stays low
    a = 32'h1; b = 32'h1F; op = 4'd3; in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    flush = 1;
    tick;
    flush = 0;
    chk("flush.idle", W'({in_ready, out_valid}), W'(2'b10));
    chk("flush.res", addr, FAST ? 32'h8000_0000 : 32'h7);
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick; seen |= out_valid; end
    chk("flush.no_valid", W'(seen), W'(0));
    do_op(32'h5, 32'h7, 4'd6, model(32'h5, 32'h7, 4'd6), "flush_sub", 0);

    // Flush in IDLE blocks acceptance
    a = 32'h1; b = 32'h1; op = 4'd5; in_valid = 1; flush = 1;
    tick;
    in_valid = 0; flush = 0;
    chk("flush_idle.blocked", W'({in_ready, out_valid}), W'(2'b10));
    tick;
    chk("flush_idle.res", addr, 32'hFFFF_FFFE);

    // Tri-state drive
    prev = addr;
    chk("bus.off", W'(bus === prev), W'(0));
    bus_en = 1; #1;
    chk("bus.on", bus, 32'hFFFF_FFFE);
    chk("addr.both", addr, 32'hFFFF_FFFE);
    bus_en = 0;

    // Async reset in the middle of a shift
    a = 32'h1; b = 32'h1F; op = 4'd3; in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    rst = 1; #1;
    chk("rst_mid.hs", W'({in_ready, out_valid}), W'(2'b10));
    chk("rst_mid.res", addr, '0);
    chk("rst_mid.flags", W'({alu_eq, alu_lt, alu_ltu, op_err}), W'(0));
    #1 rst = 0;
    tick;
    chk("rst_mid.no_valid", W'(out_valid), W'(0));
    do_op(32'h5, 32'h7, 4'd6, model(32'h5, 32'h7, 4'd6), "rst_sub", 0);

    // Random ops against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] ra, rb;
      logic [3:0] rop;
      ra  = $urandom;
      rb  = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
      if ($urandom_range(0, 9) == 0) rb = ra;
      rop = 4'($urandom_range(0, 15));
      do_op(ra, rb, rop, model(ra, rb, rop), $sformatf("rnd%0d", i), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
